// File: rtl/he_lut_apply_if.sv
// Stream bundle for the LUT-apply stage: LUT load stream, pixel source/sink handshake and status.
// The slave modport is the LUT-apply block; the master is whatever drives it.
interface he_lut_apply_if;
   logic       lut_done;
   logic [7:0] lut_data;
   logic       in_valid;
   logic [7:0] in_pixel;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_pixel;
   logic       out_ready;
   logic       out_last;
   logic       lut_loaded;
   logic       frame_done;

   modport master (
      output lut_done, lut_data, in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel, out_last, lut_loaded, frame_done
   );

   modport slave (
      input  lut_done, lut_data, in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel, out_last, lut_loaded, frame_done
   );
endinterface

// File: rtl/he_lut_apply.sv
// Histogram-equalization LUT apply: captures a NUM_BINS-entry LUT stream, then maps
// NUM_PIXELS source pixels through it with a one-deep valid/ready output register.
module he_lut_apply #(
   parameter int NUM_BINS   = 256,
   parameter int NUM_PIXELS = 290400
) (
   input  logic            clk,
   input  logic            reset,
   he_lut_apply_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_APPLY,
      ST_DONE
   } state_t;

   state_t      state_q,      state_d;
   logic [8:0]  load_cnt_q,   load_cnt_d;
   logic [19:0] in_cnt_q,     in_cnt_d;
   logic [19:0] out_cnt_q,    out_cnt_d;
   logic        out_valid_q,  out_valid_d;
   logic [7:0]  out_pixel_q,  out_pixel_d;
   logic        out_last_q,   out_last_d;
   logic        lut_loaded_q, lut_loaded_d;
   logic        frame_done_q, frame_done_d;

   logic [7:0]  lut_q [NUM_BINS];
   logic        lut_we;
   logic        in_ready;
   logic        in_xfer;
   logic        out_xfer;

   // Output register can take a new pixel when empty or draining this cycle.
   assign in_ready = (state_q == ST_APPLY) && (in_cnt_q < 20'(NUM_PIXELS))
                     && (!out_valid_q || bus.out_ready);
   assign in_xfer  = bus.in_valid && in_ready;
   assign out_xfer = out_valid_q && bus.out_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d      = state_q;
      load_cnt_d   = load_cnt_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      out_valid_d  = out_valid_q;
      out_pixel_d  = out_pixel_q;
      out_last_d   = out_last_q;
      lut_loaded_d = lut_loaded_q;
      frame_done_d = frame_done_q;
      lut_we       = 1'b0;

      unique case (state_q)
         ST_LOAD: begin
            if (bus.lut_done) begin
               lut_we     = 1'b1;
               load_cnt_d = load_cnt_q + 9'd1;
               if (load_cnt_q == 9'(NUM_BINS - 1)) begin
                  state_d      = ST_APPLY;
                  lut_loaded_d = 1'b1;
               end
            end else if (load_cnt_q != 9'd0) begin
               // A broken stream restarts framing at entry 0.
               load_cnt_d = 9'd0;
            end
         end

         ST_APPLY: begin
            if (in_xfer) begin
               in_cnt_d    = in_cnt_q + 20'd1;
               out_valid_d = 1'b1;
               out_pixel_d = lut_q[bus.in_pixel];
               out_last_d  = (in_cnt_q == 20'(NUM_PIXELS - 1));
            end else if (out_xfer) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end

            if (out_xfer) begin
               out_cnt_d = out_cnt_q + 20'd1;
               // Outputs leave in input order, so the final count marks the out_last beat.
               if (out_cnt_q == 20'(NUM_PIXELS - 1)) begin
                  state_d      = ST_DONE;
                  frame_done_d = 1'b1;
               end
            end
         end

         ST_DONE: begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end

         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         state_q      <= ST_LOAD;
         load_cnt_q   <= 9'd0;
         in_cnt_q     <= 20'd0;
         out_cnt_q    <= 20'd0;
         out_valid_q  <= 1'b0;
         out_pixel_q  <= 8'd0;
         out_last_q   <= 1'b0;
         lut_loaded_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_cnt_q   <= load_cnt_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         out_valid_q  <= out_valid_d;
         out_pixel_q  <= out_pixel_d;
         out_last_q   <= out_last_d;
         lut_loaded_q <= lut_loaded_d;
         frame_done_q <= frame_done_d;
      end
   end

   // NOTE: the LUT storage has no reset; APPLY is only reachable after every entry is written.
   always_ff @(posedge clk) begin
      if (lut_we) begin
         lut_q[load_cnt_q[7:0]] <= bus.lut_data;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_pixel  = out_pixel_q;
   assign bus.out_last   = out_last_q;
   assign bus.lut_loaded = lut_loaded_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: doc/he_lut_apply.md
HE_LUT_APPLY -- requirements
Module: he_lut_apply

Interface
REQ-001 Parameter: NUM_BINS, default 256, number of LUT entries received and stored.
REQ-002 Parameter: NUM_PIXELS, default 290400 (660x440), pixels mapped per frame.
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: lut_done  input  1  LUT stream qualifier from the equalizer; each high cycle carries one entry, beginning at entry 0.
REQ-006 Port: lut_data  input  8  LUT entry value, sampled while lut_done=1.
REQ-007 Port: in_valid  input  1  source pixel valid.
REQ-008 Port: in_pixel  input  8  source pixel value (LUT index).
REQ-009 Port: in_ready  output  1  block accepts in_pixel this cycle.
REQ-010 Port: out_valid  output  1  out_pixel valid.
REQ-011 Port: out_pixel  output  8  equalized pixel, equal to lut[in_pixel].
REQ-012 Port: out_ready  input  1  sink accepts out_pixel this cycle.
REQ-013 Port: out_last  output  1  high with the NUM_PIXELS-th output pixel.
REQ-014 Port: lut_loaded  output  1  high once all NUM_BINS entries are stored.
REQ-015 Port: frame_done  output  1  high once the last output pixel is accepted.

Function
REQ-016 States: LOAD, APPLY, DONE; LOAD is entered from reset.
REQ-017 LOAD: on each cycle with lut_done=1, the block SHALL write lut_data into lut[load_cnt] and increment load_cnt (9 bit).
REQ-018 LOAD: the first lut_done=1 cycle after reset is entry 0; no other framing is used.
REQ-019 LOAD: lut_done falling to 0 with 0 < load_cnt < NUM_BINS SHALL reset load_cnt to 0; entries already written are overwritten by the next stream.
REQ-020 LOAD -> APPLY when entry NUM_BINS-1 is written; lut_loaded=1 from the next cycle onward.
REQ-021 APPLY/DONE: lut_done and lut_data SHALL be ignored, so a producer holding lut_done=1 and repeating the final entry has no effect.
REQ-022 in_ready = (state==APPLY) and (in_cnt < NUM_PIXELS) and (out_valid==0 or out_ready==1).
REQ-023 An input transfer occurs when in_valid=1 and in_ready=1; in_cnt (20 bit) then increments.
REQ-024 Latency: on the edge of an input transfer, out_pixel <= lut[in_pixel] and out_valid <= 1, so the output is visible one cycle later.
REQ-025 While out_valid=1 and out_ready=0, out_pixel, out_valid and out_last SHALL hold stable.
REQ-026 When an output transfer (out_valid=1, out_ready=1) coincides with an input transfer, the new pixel SHALL replace the old one and out_valid SHALL stay 1; this gives full throughput of one pixel per cycle.
REQ-027 When an output transfer occurs with no input transfer, out_valid SHALL go to 0 on the next edge.
REQ-028 out_cnt (20 bit) SHALL increment on each output transfer.
REQ-029 out_last=1 SHALL be registered alongside the output produced by the transfer with in_cnt == NUM_PIXELS-1.
REQ-030 The output transfer with out_last=1 SHALL cause APPLY -> DONE; frame_done=1 from the next cycle onward.
REQ-031 DONE: in_ready=0 and out_valid=0; the block holds until reset.
REQ-032 in_valid during LOAD SHALL NOT be accepted and SHALL NOT alter any state.
REQ-033 The LUT is 256x8 registers and is not cleared by reset; outputs never read an unwritten entry because APPLY requires a full load.

Reset
REQ-034 Asserting reset at any time, including mid-load or mid-frame, SHALL immediately force: state=LOAD, load_cnt=0, in_cnt=0, out_cnt=0, out_valid=0, out_pixel=0, out_last=0, in_ready=0, lut_loaded=0, frame_done=0.
REQ-035 After reset is released, a fresh complete LUT stream is required before any pixel is accepted.

Verification (NUM_PIXELS=4 override unless stated)
REQ-036 LUT entry k=255-k streamed for 256 cycles, then pixels 0,1,128,255 with out_ready=1 -> outputs 255,254,127,0 at 1-cycle latency, out_last on the fourth, frame_done=1 one cycle later.
REQ-037 lut_done high for 100 cycles, low 1 cycle, then a full 256-entry stream -> lut_loaded=0 until the full stream completes; mappings reflect only the second stream.
REQ-038 out_ready held 0 for 3 cycles after the first output -> in_ready=0 and out_pixel stable throughout; no pixel lost or duplicated when out_ready returns to 1.
REQ-039 lut_done held 1 with repeated lut_data=0x55 after 256 entries -> LUT unchanged; identity LUT maps 0x55 to 0x55.
REQ-040 reset asserted after 2 of 4 pixels -> all outputs 0 in the same cycle; with no lut_done pulses afterwards, in_ready stays 0.
REQ-041 Default parameters, in_valid=1 and out_ready=1 continuously -> 290400 outputs in 290401 cycles after lut_loaded, with exactly one out_last.
